// File: rtl/smi_frame_arbiter_x4_pkg.sv
// rtl/smi_frame_arbiter_x4_pkg.sv - shared types and constants for the 4-way SMI frame arbiter
package smi_frame_arbiter_x4_pkg;

  // Number of requesters sharing the downstream channel
  localparam int unsigned NumInputs = 4;

  // Arbiter state: IDLE arbitrates, GRANT forwards one whole frame
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Input index reached by stepping 'offset' positions past 'last' (mod 4)
  function automatic logic [1:0] rr_pos(input logic [1:0] last, input int unsigned offset);
    return last + 2'(offset);
  endfunction

endpackage

// File: rtl/smi_frame_arbiter_x4_rr_select.sv
// rtl/smi_frame_arbiter_x4_rr_select.sv - combinational 4-way rotate-priority pick
module smi_rr_select
  import smi_frame_arbiter_x4_pkg::*;
(
  input  logic [NumInputs-1:0] req,
  input  logic [1:0]           last,
  output logic                 any,
  output logic [1:0]           sel
);

  logic       found;
  logic [1:0] idx;

  // Scan last+1, last+2, ... last+4 and keep the first requesting input
  always_comb begin
    any   = |req;
    sel   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int unsigned k = 1; k <= NumInputs; k++) begin
      idx = rr_pos(last, k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/smi_frame_arbiter_x4.sv
// rtl/smi_frame_arbiter_x4.sv - four-to-one round-robin SMI frame arbiter with registered output
module smi_frame_arbiter_x4
  import smi_frame_arbiter_x4_pkg::*;
#(
  parameter int FlitWidth = 4,
  parameter int EofcMask  = FlitWidth - 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NumInputs-1:0]         smiInReady,
  input  logic [8*NumInputs-1:0]       smiInEofc,
  input  logic [NumInputs*FlitWidth*8-1:0] smiInData,
  output logic [NumInputs-1:0]         smiInStop,
  output logic                         smiOutReady,
  output logic [7:0]                   smiOutEofc,
  output logic [FlitWidth*8-1:0]       smiOutData,
  input  logic                         smiOutStop,
  output logic                         grantValid,
  output logic [1:0]                   grantIndex
);

  localparam int DataW = FlitWidth * 8;
  localparam logic [7:0] EofcMaskB = 8'(EofcMask);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic [1:0]       rr_last_q, rr_last_d;
  logic             grant_valid_q, grant_valid_d;
  logic             out_ready_q, out_ready_d;
  logic [7:0]       out_eofc_q, out_eofc_d;
  logic [DataW-1:0] out_data_q, out_data_d;

  logic [7:0]       in_eofc [NumInputs];
  logic [DataW-1:0] in_data [NumInputs];

  logic             rr_any;
  logic [1:0]       rr_sel;
  logic             out_halt;
  logic             g_ready;
  logic [7:0]       g_eofc;
  logic [DataW-1:0] g_data;
  logic             accept;

  // Per-input views of the packed EOFC and data buses
  for (genvar i = 0; i < NumInputs; i++) begin : g_unpack
    assign in_eofc[i] = smiInEofc[8*i +: 8];
    assign in_data[i] = smiInData[DataW*i +: DataW];
  end

  smi_rr_select u_rr_select (
    .req  (smiInReady),
    .last (rr_last_q),
    .any  (rr_any),
    .sel  (rr_sel)
  );

  // A valid output flit that downstream refuses freezes the whole output stage
  assign out_halt = out_ready_q & smiOutStop;
  assign g_ready  = smiInReady[grant_idx_q];
  assign g_eofc   = in_eofc[grant_idx_q];
  assign g_data   = in_data[grant_idx_q];
  assign accept   = (state_q == GRANT) && g_ready && !out_halt;

  // Next-state, grant bookkeeping, output stage load and per-input stops
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    rr_last_d     = rr_last_q;
    out_ready_d   = out_ready_q;
    out_eofc_d    = out_eofc_q;
    out_data_d    = out_data_q;
    smiInStop     = '1;

    // An unhalted output stage drains unless refilled below
    if (!out_halt) begin
      out_ready_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d       = GRANT;
          grant_idx_d   = rr_sel;
          grant_valid_d = 1'b1;
        end
      end
      GRANT: begin
        smiInStop[grant_idx_q] = out_halt;
        if (accept) begin
          out_ready_d = 1'b1;
          out_data_d  = g_data;
          out_eofc_d  = g_eofc & EofcMaskB;
          // Frame end is judged on the raw EOFC, before masking
          if (g_eofc != 8'd0) begin
            state_d       = IDLE;
            rr_last_d     = grant_idx_q;
            grant_valid_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Control registers; rrLast resets to 3 so input 0 is first in line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      rr_last_q     <= 2'd3;
      out_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      rr_last_q     <= rr_last_d;
      out_ready_q   <= out_ready_d;
    end
  end

  // Output payload registers carry no reset; they are qualified by smiOutReady
  always_ff @(posedge clk) begin
    out_eofc_q <= out_eofc_d;
    out_data_q <= out_data_d;
  end

  assign smiOutReady = out_ready_q;
  assign smiOutEofc  = out_eofc_q;
  assign smiOutData  = out_data_q;
  assign grantValid  = grant_valid_q;
  assign grantIndex  = grant_idx_q;

endmodule
